// File: rtl/safe_bus_switch_ctrl_if.sv
// rtl/safe_bus_switch_ctrl_if.sv - config request, OBI observation and mux control bundle
// slave modport faces the controller, master modport faces the CSR/FSM plus bus observer side.
interface safe_bus_switch_ctrl_if #(
    parameter int TIMEOUT_W = 16
);
    logic                 cfg_valid_i;
    logic                 cfg_single_i;
    logic                 cfg_master_i;
    logic                 cfg_ready_o;
    logic [3:0]           obs_req_i;
    logic [3:0]           obs_gnt_i;
    logic [3:0]           obs_rvalid_i;
    logic [TIMEOUT_W-1:0] timeout_i;
    logic [3:0]           gate_o;
    logic                 bus_config_o;
    logic                 master_core_o;
    logic                 done_o;
    logic                 timeout_err_o;
    logic                 outst_err_o;

    modport slave (
        input  cfg_valid_i,
        input  cfg_single_i,
        input  cfg_master_i,
        output cfg_ready_o,
        input  obs_req_i,
        input  obs_gnt_i,
        input  obs_rvalid_i,
        input  timeout_i,
        output gate_o,
        output bus_config_o,
        output master_core_o,
        output done_o,
        output timeout_err_o,
        output outst_err_o
    );

    modport master (
        output cfg_valid_i,
        output cfg_single_i,
        output cfg_master_i,
        input  cfg_ready_o,
        output obs_req_i,
        output obs_gnt_i,
        output obs_rvalid_i,
        output timeout_i,
        input  gate_o,
        input  bus_config_o,
        input  master_core_o,
        input  done_o,
        input  timeout_err_o,
        input  outst_err_o
    );
endinterface

// File: rtl/safe_bus_switch_ctrl.sv
// rtl/safe_bus_switch_ctrl.sv - gate, drain, switch and release sequencer for the dual-core bus mux
// Optional gate+drain timeout abort is enabled by defining SAFE_BUS_SWITCH_TIMEOUT_EN.
module safe_bus_switch_ctrl #(
    parameter int MAX_OUTST = 4,
    parameter int TIMEOUT_W = 16
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    safe_bus_switch_ctrl_if.slave bus
);
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

`ifdef SAFE_BUS_SWITCH_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_GATE, S_DRAIN, S_SWITCH, S_RELEASE, S_ABORT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_GATE, S_DRAIN, S_SWITCH, S_RELEASE
    } state_t;
`endif

    state_t             r_state;
    logic [3:0]         r_gate;
    logic               r_bus_config;
    logic               r_master_core;
    logic               r_ready;
    logic               r_done;
    logic               r_req_single;
    logic               r_req_master;
    logic               r_outst_err;
    logic [3:0][CW-1:0] r_cnt;

    logic [3:0][CW-1:0] w_cnt_nxt;
    logic [3:0]         w_inc;
    logic [3:0]         w_dec;
    logic [3:0]         w_cnt_err;
    logic [3:0]         w_gate_ok;
    logic               w_all_idle;

    assign w_inc     = bus.obs_req_i & bus.obs_gnt_i;
    assign w_dec     = bus.obs_rvalid_i;
    // A channel may only be gated when no request is left hanging ungranted downstream.
    assign w_gate_ok = ~bus.obs_req_i | bus.obs_gnt_i;

    always_comb begin
        w_all_idle = 1'b1;
        w_cnt_nxt  = r_cnt;
        w_cnt_err  = 4'b0000;
        for (int ch = 0; ch < 4; ch++) begin
            if (w_inc[ch] && !w_dec[ch]) begin
                if (r_cnt[ch] == MAX_CNT) w_cnt_err[ch] = 1'b1;
                else                      w_cnt_nxt[ch] = r_cnt[ch] + CNT_ONE;
            end else if (w_dec[ch] && !w_inc[ch]) begin
                if (r_cnt[ch] == '0) w_cnt_err[ch] = 1'b1;
                else                 w_cnt_nxt[ch] = r_cnt[ch] - CNT_ONE;
            end
            if (w_cnt_nxt[ch] != '0) w_all_idle = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt       <= '0;
            r_outst_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (|w_cnt_err) r_outst_err <= 1'b1;
        end
    end

`ifdef SAFE_BUS_SWITCH_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMR_ONE = TIMEOUT_W'(1);
    logic [TIMEOUT_W-1:0] r_timer;
    logic                 r_timeout_err;
    logic                 w_expired;

    assign w_expired = (bus.timeout_i != '0) && (r_timer == bus.timeout_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_timer       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cfg_valid_i) begin
                        r_timer       <= '0;
                        r_timeout_err <= 1'b0;
                    end
                end
                S_GATE, S_DRAIN: r_timer <= r_timer + TMR_ONE;
                S_ABORT:         r_timeout_err <= 1'b1;
                default:         r_timer <= r_timer;
            endcase
        end
    end

    assign bus.timeout_err_o = r_timeout_err;
`else
    localparam logic w_expired = 1'b0;
    assign bus.timeout_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= S_IDLE;
            r_gate        <= 4'b0000;
            r_bus_config  <= 1'b0;
            r_master_core <= 1'b0;
            r_ready       <= 1'b1;
            r_done        <= 1'b0;
            r_req_single  <= 1'b0;
            r_req_master  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cfg_valid_i) begin
                        r_req_single <= bus.cfg_single_i;
                        r_req_master <= bus.cfg_master_i;
                        if (bus.cfg_single_i == r_bus_config &&
                            bus.cfg_master_i == r_master_core) begin
                            r_done <= 1'b1;
                        end else begin
                            r_ready <= 1'b0;
                            r_state <= S_GATE;
                        end
                    end
                end
                S_GATE: begin
                    if (w_expired) begin
`ifdef SAFE_BUS_SWITCH_TIMEOUT_EN
                        r_done  <= 1'b1;
                        r_state <= S_ABORT;
`endif
                    end else begin
                        r_gate <= r_gate | w_gate_ok;
                        if (&r_gate) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_expired) begin
`ifdef SAFE_BUS_SWITCH_TIMEOUT_EN
                        r_done  <= 1'b1;
                        r_state <= S_ABORT;
`endif
                    end else if (w_all_idle) begin
                        r_state <= S_SWITCH;
                    end
                end
                S_SWITCH: begin
                    r_bus_config  <= r_req_single;
                    r_master_core <= r_req_master;
                    r_done        <= 1'b1;
                    r_state       <= S_RELEASE;
                end
                S_RELEASE: begin
                    r_gate  <= 4'b0000;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
`ifdef SAFE_BUS_SWITCH_TIMEOUT_EN
                S_ABORT: begin
                    r_gate  <= 4'b0000;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
`endif
                default: begin
                    r_gate  <= 4'b0000;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cfg_ready_o   = r_ready;
    assign bus.gate_o        = r_gate;
    assign bus.bus_config_o  = r_bus_config;
    assign bus.master_core_o = r_master_core;
    assign bus.done_o        = r_done;
    assign bus.outst_err_o   = r_outst_err;
endmodule

// File: tb/tb_safe_bus_switch_ctrl.sv
// tb/tb_safe_bus_switch_ctrl.sv - directed and randomized bench for safe_bus_switch_ctrl
module tb_safe_bus_switch_ctrl;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    safe_bus_switch_ctrl_if #(.TIMEOUT_W(16)) bus ();
    safe_bus_switch_ctrl #(.MAX_OUTST(MAXO), .TIMEOUT_W(16)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int m_cnt[4];
    bit m_oerr;
    bit m_single, m_master;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; advances the outstanding-count model from the inputs present at the edge.
    task automatic cyc();
        logic [3:0] g0, rq, gn, rv;
        logic bc0, mc0;
        g0 = bus.gate_o; bc0 = bus.bus_config_o; mc0 = bus.master_core_o;
        rq = bus.obs_req_i; gn = bus.obs_gnt_i; rv = bus.obs_rvalid_i;
        @(posedge clk);
        for (int ch = 0; ch < 4; ch++) begin
            if (rq[ch] && gn[ch] && !rv[ch]) begin
                if (m_cnt[ch] == MAXO) m_oerr = 1'b1; else m_cnt[ch]++;
            end else if (rv[ch] && !(rq[ch] && gn[ch])) begin
                if (m_cnt[ch] == 0) m_oerr = 1'b1; else m_cnt[ch]--;
            end
        end
        #1;
        chk("outst_err", bus.outst_err_o, m_oerr);
        for (int ch = 0; ch < 4; ch++)
            if (!g0[ch] && bus.gate_o[ch]) chk("gate_rise_req_pending", rq[ch] && !gn[ch], 1'b0);
        if (bus.bus_config_o !== bc0 || bus.master_core_o !== mc0) chk("cfg_change_gated", g0, 4'hF);
    endtask

    task automatic idle_inputs();
        bus.cfg_valid_i = 1'b0; bus.obs_req_i = 4'h0; bus.obs_gnt_i = 4'h0; bus.obs_rvalid_i = 4'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        bus.timeout_i = '0;
        rst_n = 1'b0;
        for (int ch = 0; ch < 4; ch++) m_cnt[ch] = 0;
        m_oerr = 1'b0; m_single = 1'b0; m_master = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_gate"}, bus.gate_o, 4'h0);
        chk({tag, "_cfg"}, {bus.bus_config_o, bus.master_core_o}, 2'b00);
        chk({tag, "_ready"}, bus.cfg_ready_o, 1'b1);
        chk({tag, "_done"}, bus.done_o, 1'b0);
        chk({tag, "_errs"}, {bus.timeout_err_o, bus.outst_err_o}, 2'b00);
    endtask

    task automatic rand_traffic();
        for (int ch = 0; ch < 4; ch++) begin
            bus.obs_req_i[ch]    = 1'($urandom_range(0, 1));
            bus.obs_gnt_i[ch]    = bus.obs_req_i[ch] && !bus.gate_o[ch] && (m_cnt[ch] < MAXO)
                                   && ($urandom_range(0, 1) == 1);
            bus.obs_rvalid_i[ch] = (m_cnt[ch] > 0) && ($urandom_range(0, 1) == 1);
        end
    endtask

    task automatic request(input bit s, input bit m);
        bus.cfg_single_i = s; bus.cfg_master_i = m; bus.cfg_valid_i = 1'b1;
        cyc();
        bus.cfg_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int n);
        n = 0;
        while (!bus.done_o && n < budget) begin cyc(); n++; end
        chk({tag, "_done_seen"}, bus.done_o, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bit s, m, noop;
        bus.cfg_single_i = 1'b0; bus.cfg_master_i = 1'b0;
        do_reset();
        check_reset_vals("reset");

        // Idle bus switch to single bus: gate +1, config & done +4, gate low +5
        request(1'b1, 1'b0);
        chk("t1_ready_low", bus.cfg_ready_o, 1'b0);
        chk("t1_gate_e0", bus.gate_o, 4'h0);
        cyc(); chk("t1_gate_e1", bus.gate_o, 4'hF);
        cyc(); cyc();
        chk("t1_cfg_e3", bus.bus_config_o, 1'b0);
        chk("t1_done_e3", bus.done_o, 1'b0);
        cyc();
        chk("t1_cfg_e4", {bus.bus_config_o, bus.master_core_o}, 2'b10);
        chk("t1_done_e4", bus.done_o, 1'b1);
        chk("t1_gate_e4", bus.gate_o, 4'hF);
        cyc();
        chk("t1_gate_e5", bus.gate_o, 4'h0);
        chk("t1_done_e5", bus.done_o, 1'b0);
        chk("t1_ready_e5", bus.cfg_ready_o, 1'b1);

        // Request equal to current config is a no-op
        request(1'b1, 1'b0);
        chk("t4_done", bus.done_o, 1'b1);
        chk("t4_gate", bus.gate_o, 4'h0);
        chk("t4_ready", bus.cfg_ready_o, 1'b1);
        cyc();
        chk("t4_done_pulse", bus.done_o, 1'b0);
        chk("t4_gate_after", bus.gate_o, 4'h0);

        // ch2 request pending ungranted holds its gate bit off
        bus.obs_req_i = 4'b0100;
        request(1'b0, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            cyc(); chk($sformatf("t2_gate_e%0d", k), bus.gate_o, 4'b1011);
        end
        bus.obs_gnt_i = 4'b0100;
        cyc(); chk("t2_gate_gnt", bus.gate_o, 4'hF);
        idle_inputs();
        cyc(); cyc();
        bus.obs_rvalid_i = 4'b0100;
        cyc(); bus.obs_rvalid_i = 4'h0;
        chk("t2_cfg_before", {bus.bus_config_o, bus.master_core_o}, 2'b10);
        cyc();
        chk("t2_cfg_after", {bus.bus_config_o, bus.master_core_o}, 2'b01);
        chk("t2_done", bus.done_o, 1'b1);
        cyc();

        // ch0 holds two outstanding; switch one cycle after the second rvalid
        bus.obs_req_i = 4'b0001; bus.obs_gnt_i = 4'b0001;
        cyc(); cyc();
        idle_inputs();
        request(1'b1, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            bus.obs_rvalid_i = (k == 5 || k == 8) ? 4'b0001 : 4'b0000;
            cyc();
            if (k < 9) chk($sformatf("t3_cfg_hold_e%0d", k), {bus.bus_config_o, bus.done_o}, 2'b00);
            else       chk("t3_cfg_switch", {bus.bus_config_o, bus.master_core_o, bus.done_o}, 3'b111);
        end
        bus.obs_rvalid_i = 4'h0;
        cyc();

        // Underflow sets the sticky error, then reset during DRAIN
        bus.obs_rvalid_i = 4'b0010;
        cyc(); bus.obs_rvalid_i = 4'h0;
        chk("t6_underflow", bus.outst_err_o, 1'b1);
        bus.obs_req_i = 4'b0001; bus.obs_gnt_i = 4'b0001;
        cyc(); idle_inputs();
        request(1'b0, 1'b0);
        cyc(); cyc(); cyc();
        chk("t6_in_drain_gate", bus.gate_o, 4'hF);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("t6_async");
        do_reset();
        check_reset_vals("t6_post");

        // Timeout with ch3 never returning rvalid
        bus.obs_req_i = 4'b1000; bus.obs_gnt_i = 4'b1000;
        cyc(); idle_inputs();
        bus.timeout_i = 16'd10;
        request(1'b1, 1'b0);
`ifdef SAFE_BUS_SWITCH_TIMEOUT_EN
        wait_done("t5", 40, n);
        chk("t5_latency_range", (n >= 10 && n <= 13), 1'b1);
        chk("t5_cfg_kept", {bus.bus_config_o, bus.master_core_o}, 2'b00);
        cyc();
        chk("t5_timeout_err", bus.timeout_err_o, 1'b1);
        chk("t5_gate_low", bus.gate_o, 4'h0);
        chk("t5_ready", bus.cfg_ready_o, 1'b1);
        bus.obs_rvalid_i = 4'b1000;
        cyc(); bus.obs_rvalid_i = 4'h0;
        bus.timeout_i = '0;
        request(1'b1, 1'b0);
        chk("t5_err_cleared", bus.timeout_err_o, 1'b0);
        wait_done("t5b", 20, n);
        m_single = 1'b1; m_master = 1'b0;
`else
        repeat (30) cyc();
        chk("t5_still_waiting", {bus.gate_o, bus.bus_config_o, bus.done_o}, 6'b111100);
        bus.obs_rvalid_i = 4'b1000;
        cyc(); bus.obs_rvalid_i = 4'h0;
        wait_done("t5", 10, n);
        m_single = 1'b1; m_master = 1'b0;
`endif
        chk("t5_final_cfg", {bus.bus_config_o, bus.master_core_o}, {m_single, m_master});
        chk("t5_no_timeout_err", bus.timeout_err_o, 1'b0);
        cyc();
        bus.timeout_i = '0;

        // Randomized requests under random OBI traffic
        for (int it = 0; it < 12; it++) begin
            repeat ($urandom_range(0, 4)) begin rand_traffic(); cyc(); end
            s = 1'($urandom_range(0, 1));
            m = 1'($urandom_range(0, 1));
            noop = (s == m_single) && (m == m_master);
            rand_traffic();
            bus.cfg_single_i = s; bus.cfg_master_i = m; bus.cfg_valid_i = 1'b1;
            cyc();
            bus.cfg_valid_i = 1'b0;
            n = 0;
            while (!bus.done_o && n < 400) begin rand_traffic(); cyc(); n++; end
            chk($sformatf("rand%0d_done", it), bus.done_o, 1'b1);
            if (noop) chk($sformatf("rand%0d_noop_lat", it), n, 0);
            chk($sformatf("rand%0d_cfg", it), {bus.bus_config_o, bus.master_core_o}, {s, m});
            m_single = s; m_master = m;
            rand_traffic(); cyc();
            chk($sformatf("rand%0d_idle", it), {bus.cfg_ready_o, bus.gate_o, bus.done_o}, 6'b100000);
        end

        idle_inputs();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
